// File: rtl/mode_counter_pkg.sv
// Shared direction encoding for the up/down mode counter.
package mode_counter_pkg;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    typedef enum logic {
        DIR_UP   = MODE_UP,
        DIR_DOWN = MODE_DOWN
    } dir_e;

endpackage : mode_counter_pkg

// File: rtl/mode_counter_next.sv
// Combinational next-count step: +1 or -1 modulo 2^sz depending on direction.
module mode_counter_next
    import mode_counter_pkg::*;
#(
    parameter int sz = 8
) (
    input  logic [sz-1:0] i_value,
    input  logic          i_mode,
    output logic [sz-1:0] o_next
);

    localparam logic [sz-1:0] ONE = sz'(1'b1);

    // Direction select; any unknown mode falls through to counting up.
    always_comb begin
        o_next = i_value + ONE;
        case (dir_e'(i_mode))
            DIR_UP:   o_next = i_value + ONE;
            DIR_DOWN: o_next = i_value - ONE;
            default:  o_next = i_value + ONE;
        endcase
    end

endmodule : mode_counter_next

// File: rtl/mode_counter.sv
// Free-running up/down counter with async active-low reset.
// Optional terminal-count output tc is enabled by defining MODE_COUNTER_TC_EN.
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int sz = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mode,
    output logic [sz-1:0] counter
`ifdef MODE_COUNTER_TC_EN
    ,
    output logic          tc
`endif
);

    localparam logic [sz-1:0] CNT_ZERO = {sz{1'b0}};
    localparam logic [sz-1:0] CNT_MAX  = {sz{1'b1}};

    logic [sz-1:0] r_count;
    logic [sz-1:0] w_next;

    mode_counter_next #(
        .sz (sz)
    ) u_next (
        .i_value (r_count),
        .i_mode  (mode),
        .o_next  (w_next)
    );

    // Count register; reset clears it immediately without waiting for clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= CNT_ZERO;
        end else begin
            r_count <= w_next;
        end
    end

    assign counter = r_count;

`ifdef MODE_COUNTER_TC_EN
    // Terminal count: the value from which the next step wraps.
    always_comb begin
        tc = 1'b0;
        if (!reset) begin
            tc = 1'b0;
        end else if (mode == MODE_DOWN) begin
            tc = (r_count == CNT_ZERO);
        end else begin
            tc = (r_count == CNT_MAX);
        end
    end
`endif

`ifndef SYNTHESIS
    a_wrap_up: assert property (@(posedge clk) disable iff (!reset)
        (mode == MODE_UP && r_count == CNT_MAX) |=> (r_count == CNT_ZERO))
        else $error("mode_counter: up-count did not wrap to zero");

    a_wrap_down: assert property (@(posedge clk) disable iff (!reset)
        (mode == MODE_DOWN && r_count == CNT_ZERO) |=> (r_count == CNT_MAX))
        else $error("mode_counter: down-count did not wrap to max");

    a_mode_known: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown(mode))
        else $error("mode_counter: mode is X/Z out of reset");

    a_reset_hold: assert property (@(posedge clk)
        !reset |-> (r_count == CNT_ZERO))
        else $error("mode_counter: counter nonzero during reset");
`endif

endmodule : mode_counter

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter: sz=8 main instance plus an sz=1 instance.
module tb_mode_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       reset1;
    logic       mode1;
    logic [7:0] counter;
    logic [0:0] counter1;
`ifdef MODE_COUNTER_TC_EN
    logic       tc;
    logic       tc1;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] model;
    logic [0:0] model1;
    logic [7:0] q[$];
    logic [0:0] q1[$];

    mode_counter #(.sz(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .counter (counter)
`ifdef MODE_COUNTER_TC_EN
        ,
        .tc      (tc)
`endif
    );

    mode_counter #(.sz(1)) dut1 (
        .clk     (clk),
        .reset   (reset1),
        .mode    (mode1),
        .counter (counter1)
`ifdef MODE_COUNTER_TC_EN
        ,
        .tc      (tc1)
`endif
    );

    always #5 clk = ~clk;

    // Drive one edge on the sz=8 instance and queue the value it should load.
    task automatic drive_edge(input logic m);
        mode  = m;
        model = (m == 1'b1) ? model - 8'd1 : model + 8'd1;
        q.push_back(model);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_edge1(input logic m);
        mode1  = m;
        model1 = (m == 1'b1) ? model1 - 1'b1 : model1 + 1'b1;
        q1.push_back(model1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        mode   = 1'b0;
        reset1 = 1'b0;
        mode1  = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (counter !== 8'd0) begin
            failures++;
            $display("FAIL reset_async: got %0d expected 0", counter);
        end
`ifdef MODE_COUNTER_TC_EN
        checks++;
        if (tc !== 1'b0) begin
            failures++;
            $display("FAIL reset_tc: got %b expected 0", tc);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (counter !== 8'd0) begin
            failures++;
            $display("FAIL reset_hold_up: got %0d expected 0", counter);
        end
        mode = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (counter !== 8'd0) begin
            failures++;
            $display("FAIL reset_hold_down: got %0d expected 0", counter);
        end
        checks++;
        if (counter1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_sz1: got %0d expected 0", counter1);
        end
    endtask

    task automatic test_up_count();
        logic [7:0] exp;
        @(negedge clk);
        mode  = 1'b0;
        reset = 1'b1;
        model = 8'd0;
        for (int i = 0; i < 20; i++) begin
            drive_edge(1'b0);
            exp = q.pop_front();
            checks++;
            if (counter !== exp) begin
                failures++;
                $display("FAIL up_count step %0d: got %0d expected %0d", i, counter, exp);
            end
        end
        checks++;
        if (counter !== 8'd20) begin
            failures++;
            $display("FAIL up_count_final: got %0d expected 20", counter);
        end
    endtask

    task automatic test_direction_switch();
        logic [7:0] exp;
        for (int i = 0; i < 40; i++) begin
            drive_edge(1'b1);
            exp = q.pop_front();
            checks++;
            if (counter !== exp) begin
                failures++;
                $display("FAIL dir_switch step %0d: got %0d expected %0d", i, counter, exp);
            end
`ifdef MODE_COUNTER_TC_EN
            checks++;
            if (tc !== (exp == 8'd0)) begin
                failures++;
                $display("FAIL dir_switch_tc step %0d: got %b expected %b", i, tc, (exp == 8'd0));
            end
`endif
        end
        checks++;
        if (counter !== 8'd236) begin
            failures++;
            $display("FAIL dir_switch_final: got %0d expected 236", counter);
        end
    endtask

    task automatic test_up_wrap();
        logic [7:0] exp;
        for (int i = 0; i < 18; i++) begin
            drive_edge(1'b0);
            exp = q.pop_front();
        end
        checks++;
        if (counter !== 8'd254) begin
            failures++;
            $display("FAIL wrap_start: got %0d expected 254", counter);
        end
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0);
            exp = q.pop_front();
            checks++;
            if (counter !== exp) begin
                failures++;
                $display("FAIL up_wrap step %0d: got %0d expected %0d", i, counter, exp);
            end
`ifdef MODE_COUNTER_TC_EN
            checks++;
            if (tc !== (exp == 8'd255)) begin
                failures++;
                $display("FAIL up_wrap_tc step %0d: got %b expected %b", i, tc, (exp == 8'd255));
            end
`endif
        end
        checks++;
        if (counter !== 8'd1) begin
            failures++;
            $display("FAIL up_wrap_final: got %0d expected 1", counter);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp;
        for (int i = 0; i < 36; i++) begin
            drive_edge(1'b0);
            exp = q.pop_front();
        end
        checks++;
        if (counter !== 8'd37) begin
            failures++;
            $display("FAIL mid_reset_start: got %0d expected 37", counter);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (counter !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset_async: got %0d expected 0", counter);
        end
        @(posedge clk);
        #1;
        checks++;
        if (counter !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset_hold: got %0d expected 0", counter);
        end
        @(negedge clk);
        reset = 1'b1;
        model = 8'd0;
        drive_edge(1'b0);
        exp = q.pop_front();
        checks++;
        if (counter !== exp) begin
            failures++;
            $display("FAIL mid_reset_first: got %0d expected %0d", counter, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            drive_edge(i[0]);
            exp = q.pop_front();
            checks++;
            if (counter !== exp) begin
                failures++;
                $display("FAIL back_to_back step %0d: got %0d expected %0d", i, counter, exp);
            end
        end
    endtask

    task automatic test_width_one();
        logic [0:0] exp;
        @(negedge clk);
        mode1  = 1'b1;
        reset1 = 1'b1;
        model1 = 1'b0;
        #1;
        checks++;
        if (counter1 !== 1'b0) begin
            failures++;
            $display("FAIL width_one_start: got %0d expected 0", counter1);
        end
        for (int i = 0; i < 4; i++) begin
            drive_edge1(1'b1);
            exp = q1.pop_front();
            checks++;
            if (counter1 !== exp) begin
                failures++;
                $display("FAIL width_one step %0d: got %0d expected %0d", i, counter1, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_direction_switch();
        test_up_wrap();
        test_mid_reset();
        test_back_to_back();
        test_width_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mode_counter

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 SHALL have parameter sz, default 8, meaning counter width in bits; legal range sz >= 1.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port mode, input, 1 bit: count direction; 0 = up, 1 = down.
REQ-005 SHALL have port counter, output, sz bits: registered count value, unsigned.
REQ-006 SHALL have port order clk, reset, mode, counter, so positional instantiation is valid.

Function
REQ-007 SHALL, on each rising clk edge with reset high and mode = 0, load counter + 1 modulo 2^sz.
REQ-008 SHALL, on each rising clk edge with reset high and mode = 1, load counter - 1 modulo 2^sz.
REQ-009 SHALL wrap up-count from 2^sz-1 to 0 and down-count from 0 to 2^sz-1, with no saturation and no stall.
REQ-010 SHALL sample mode at the clock edge; a mode change applies from the first edge after it, with no lost or extra count.
REQ-011 SHALL drive counter directly from a register, with zero combinational path from mode to counter.
REQ-012 SHALL count on every edge; the block has no enable or hold state.
REQ-013 SHALL treat an unknown mode (X/Z) as up in synthesis; simulation assertions SHALL flag it while out of reset.

Reset
REQ-014 SHALL force counter to 0 immediately when reset falls, independent of clk.
REQ-015 SHALL hold counter at 0 while reset is low, regardless of mode or clk.
REQ-016 SHALL perform the first count on the first rising clk edge after reset rises; reset mid-count discards the current value.

Configuration
REQ-017 SHALL support macro MODE_COUNTER_TC_EN.
- Defined: adds output tc (1 bit, last port) that is combinationally high when mode = 0 and counter = 2^sz-1, or when mode = 1 and counter = 0; tc is low during reset.
- Undefined: tc port and its logic are absent; all other behaviour is identical.

Structure
REQ-018 SHALL place in shared package mode_counter_pkg:
- Direction constants MODE_UP = 1'b0 and MODE_DOWN = 1'b1.
- An enum typedef for the direction.
REQ-019 SHALL implement next-value computation in one combinational sub-module, mode_counter_next (inputs: current value, mode; output: next value; parameterised by sz).
REQ-020 SHALL keep the count register and reset logic in mode_counter, plus immediate/concurrent assertions for REQ-009, REQ-013 and REQ-015, guarded for simulation only.

Verification
REQ-021 Reset: assert reset low with mode = 0 for 1 clk -> counter = 0 throughout, including asynchronously before any edge.
REQ-022 Up count: sz = 8, release reset, mode = 0 for 20 edges -> counter = 20, incrementing by 1 per edge.
REQ-023 Direction switch: from 20, set mode = 1 for 40 edges -> 19, 18, ... 0, then 255 (wrap), ending at 236.
REQ-024 Up wrap: sz = 8, count up from 254 -> 255, 0, 1; with MODE_COUNTER_TC_EN defined, tc = 1 only while counter = 255.
REQ-025 Mid-operation reset: at counter = 37, pull reset low between edges -> counter = 0 before the next edge; after release, first edge gives 1 (mode = 0).
REQ-026 Width edge: sz = 1, mode = 1 -> counter toggles 0, 1, 0, 1 on successive edges.
